// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
//   Multi-cycle RV32I-subset core (add, sub, and, or, slt, addi, lw, sw, beq,
//   bne, jal). Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB]
//   through one shared ALU. Instruction and data memories are reached over
//   req/ack handshakes, so memories may take any number of cycles to answer.
//
// Parameters
//   ADDR_W   : PC / memory address width (8..32)
//   NREGS    : architectural registers (16 or 32)
//   RESET_PC : PC loaded by reset
//
// Ports
//   clk, rst                 : clock (rising edge), synchronous active-high reset
//   imem_req/addr/ack/rdata  : instruction fetch handshake
//   dmem_req/we/addr/wdata/ack/rdata : data load/store handshake
//   pc_out                   : current PC
//   halt                     : core stopped in TRAP (left only by rst)
//   cycle_cnt, instret_cnt   : performance counters, present only when the
//                              macro PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module multicycle_datapath #(
  parameter int                ADDR_W   = 32,
  parameter int                NREGS    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halt
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  localparam int                RIDX_W  = $clog2(NREGS);
  localparam logic [5:0]        NREGS_L = 6'(NREGS);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_JAL  = 4'd10,
    OP_ILL  = 4'd11
  } op_t;

  // Register index must address an implemented register.
  function automatic logic idx_ok_f(input logic [4:0] idx);
    return ({1'b0, idx} < NREGS_L);
  endfunction

  // The single shared ALU; every non-R operation uses it as an adder.
  function automatic logic [31:0] alu_f(input op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      default: return a + b;
    endcase
  endfunction

  state_t              r_state;
  op_t                 r_op;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_ir;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [31:0]         r_imm;
  logic [31:0]         r_aluout;
  logic [31:0]         r_mdr;
  logic [31:0]         r_regs [NREGS];
  logic                r_imem_req;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic [ADDR_W-1:0]   r_dmem_addr;
  logic [31:0]         r_dmem_wdata;
  logic                r_halt;

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic [4:0]          w_rs1;
  logic [4:0]          w_rs2;
  logic [4:0]          w_rd;
  op_t                 w_dec_op;
  logic [31:0]         w_dec_imm;
  logic                w_use_rs1;
  logic                w_use_rs2;
  logic                w_use_rd;
  logic                w_dec_ok;
  logic [31:0]         w_rs1_val;
  logic [31:0]         w_rs2_val;
  logic [31:0]         w_alu_a;
  logic [31:0]         w_alu_b;
  logic [31:0]         w_alu_y;
  logic [31:0]         w_pc_ext;
  logic [ADDR_W-1:0]   w_pc_plus4;
  logic [31:0]         w_pc4_ext;
  logic                w_taken;
  logic                w_misaligned;
  logic [ADDR_W-1:0]   w_br_pc;
  logic [ADDR_W-1:0]   w_wb_pc;
  logic [31:0]         w_wb_data;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_funct7 = r_ir[31:25];

  // x0 is never written, but the explicit zero keeps reads independent of that.
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[RIDX_W-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[RIDX_W-1:0]];

  // Instruction decode: operation class, immediate and which register fields matter.
  always_comb begin
    w_dec_op  = OP_ILL;
    w_dec_imm = 32'd0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000:  w_dec_op = OP_ADD;
            3'b111:  w_dec_op = OP_AND;
            3'b110:  w_dec_op = OP_OR;
            3'b010:  w_dec_op = OP_SLT;
            default: w_dec_op = OP_ILL;
          endcase
        end else if ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)) begin
          w_dec_op = OP_SUB;
        end else begin
          w_dec_op = OP_ILL;
        end
      end
      7'b0010011: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_dec_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        w_dec_op  = (w_funct3 == 3'b000) ? OP_ADDI : OP_ILL;
      end
      7'b0000011: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_dec_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        w_dec_op  = (w_funct3 == 3'b010) ? OP_LW : OP_ILL;
      end
      7'b0100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_dec_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        w_dec_op  = (w_funct3 == 3'b010) ? OP_SW : OP_ILL;
      end
      7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_dec_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        case (w_funct3)
          3'b000:  w_dec_op = OP_BEQ;
          3'b001:  w_dec_op = OP_BNE;
          default: w_dec_op = OP_ILL;
        endcase
      end
      7'b1101111: begin
        w_use_rd  = 1'b1;
        w_dec_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        w_dec_op  = OP_JAL;
      end
      default: begin
        w_dec_op = OP_ILL;
      end
    endcase
  end

  assign w_dec_ok = (w_dec_op != OP_ILL)
                  && (!w_use_rs1 || idx_ok_f(w_rs1))
                  && (!w_use_rs2 || idx_ok_f(w_rs2))
                  && (!w_use_rd  || idx_ok_f(w_rd));

  assign w_pc_ext   = 32'(r_pc);
  assign w_pc_plus4 = r_pc + PC_STEP;
  assign w_pc4_ext  = 32'(w_pc_plus4);

  // ALU operand select: register pair for R-type, rs1+imm for addi/lw/sw,
  // PC+imm for branch and jump targets.
  always_comb begin
    w_alu_a = r_a;
    w_alu_b = r_b;
    case (r_op)
      OP_ADDI, OP_LW, OP_SW: begin
        w_alu_a = r_a;
        w_alu_b = r_imm;
      end
      OP_BEQ, OP_BNE, OP_JAL: begin
        w_alu_a = w_pc_ext;
        w_alu_b = r_imm;
      end
      default: begin
        w_alu_a = r_a;
        w_alu_b = r_b;
      end
    endcase
  end

  assign w_alu_y      = alu_f(r_op, w_alu_a, w_alu_b);
  assign w_taken      = (r_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
  assign w_misaligned = (w_alu_y[1:0] != 2'b00);
  assign w_br_pc      = w_taken ? w_alu_y[ADDR_W-1:0] : w_pc_plus4;
  assign w_wb_pc      = (r_op == OP_JAL) ? r_aluout[ADDR_W-1:0] : w_pc_plus4;

  // Writeback data source select.
  always_comb begin
    case (r_op)
      OP_LW:   w_wb_data = r_mdr;
      OP_JAL:  w_wb_data = w_pc4_ext;
      default: w_wb_data = r_aluout;
    endcase
  end

  // Control FSM with datapath registers and registered memory-interface outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_ILL;
      r_pc         <= RESET_PC;
      r_ir         <= 32'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_imm        <= 32'd0;
      r_aluout     <= 32'd0;
      r_mdr        <= 32'd0;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= {ADDR_W{1'b0}};
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= {ADDR_W{1'b0}};
      r_dmem_wdata <= 32'd0;
      r_halt       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
          r_state     <= S_FETCH;
        end
        S_FETCH: begin
          // req is already high on entry, so a zero-wait ack is taken here.
          if (imem_ack && r_imem_req) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_imm <= w_dec_imm;
          r_op  <= w_dec_op;
          if (w_dec_ok) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_TRAP;
            r_halt  <= 1'b1;
          end
        end
        S_EXEC: begin
          r_aluout <= w_alu_y;
          case (r_op)
            OP_BEQ, OP_BNE: begin
              r_pc        <= w_br_pc;
              r_imem_addr <= w_br_pc;
              r_imem_req  <= 1'b1;
              r_state     <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              if (w_misaligned) begin
                r_state <= S_TRAP;
                r_halt  <= 1'b1;
              end else begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= (r_op == OP_SW);
                r_dmem_addr  <= w_alu_y[ADDR_W-1:0];
                r_dmem_wdata <= (r_op == OP_SW) ? r_b : 32'd0;
                r_state      <= S_MEM;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_JAL: begin
              r_state <= S_WB;
            end
            default: begin
              r_state <= S_TRAP;
              r_halt  <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack && r_dmem_req) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_op == OP_LW) begin
              r_mdr   <= dmem_rdata;
              r_state <= S_WB;
            end else begin
              r_pc        <= w_pc_plus4;
              r_imem_addr <= w_pc_plus4;
              r_imem_req  <= 1'b1;
              r_state     <= S_FETCH;
            end
          end
        end
        S_WB: begin
          r_pc        <= w_wb_pc;
          r_imem_addr <= w_wb_pc;
          r_imem_req  <= 1'b1;
          r_state     <= S_FETCH;
        end
        S_TRAP: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_halt     <= 1'b1;
        end
        default: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_halt     <= 1'b1;
          r_state    <= S_TRAP;
        end
      endcase
    end
  end

  // Register file: cleared by reset, written only in WB, x0 writes dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if ((r_state == S_WB) && (w_rd != 5'd0)) begin
      r_regs[w_rd[RIDX_W-1:0]] <= w_wb_data;
    end
  end

`ifdef PERF_CNT_EN
  logic        w_retire;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  // Retirement is the PC update that closes an instruction.
  assign w_retire = ((r_state == S_EXEC) && ((r_op == OP_BEQ) || (r_op == OP_BNE)))
                  || ((r_state == S_MEM) && dmem_ack && r_dmem_req && (r_op == OP_SW))
                  || (r_state == S_WB);

  // Free-running cycle and retired-instruction counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      r_cycle_cnt   <= r_cycle_cnt + 32'd1;
      r_instret_cnt <= r_instret_cnt + {31'd0, w_retire};
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign pc_out     = r_pc;
  assign halt       = r_halt;

endmodule

// File: tb/tb_multicycle_datapath.sv
// -----------------------------------------------------------------------------
// tb_multicycle_datapath
//   Directed test of multicycle_datapath with a behavioural instruction memory
//   (zero-wait, ack gateable) and a data memory with a programmable ack delay.
//   Register values are observed through store data on the data bus.
// -----------------------------------------------------------------------------
module tb_multicycle_datapath;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] pc_out;
  logic        halt;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  multicycle_datapath #(.ADDR_W(32), .NREGS(32), .RESET_PC(32'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc_out     (pc_out),
    .halt       (halt)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic        imem_en;
  logic [3:0]  dly;
  logic [3:0]  dcnt;

  assign imem_ack   = imem_req & imem_en;
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ack   = dmem_req && (dcnt == dly);
  assign dmem_rdata = dmem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (rst || !dmem_req || dmem_ack) dcnt <= 4'd0;
    else                              dcnt <= dcnt + 4'd1;
  end

  // Logs of completed fetches/stores and handshake counts
  logic [31:0] flog [$];
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  int          n_dack;
  int          hold_cnt;
  initial begin
    n_dack   = 0;
    hold_cnt = 0;
  end

  always @(posedge clk) begin
    if (!rst && imem_req && imem_ack) flog.push_back(imem_addr);
    if (!rst && dmem_req && dmem_ack) begin
      n_dack <= n_dack + 1;
      if (dmem_we) begin
        dmem[dmem_addr[7:2]] <= dmem_wdata;
        st_addr.push_back(dmem_addr);
        st_data.push_back(dmem_wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (dmem_req && dmem_we && (dmem_addr == 32'd8) && (dmem_wdata == 32'd12))
      hold_cnt <= hold_cnt + 1;
  end

  // Checking
  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_halt(input int max_cyc);
    int n;
    n = 0;
    while (!halt && (n < max_cyc)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("halt_reached", {31'd0, halt}, 32'd1);
  endtask

  task automatic check_no_req(input string tag, input int cycles);
    int nreq;
    nreq = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req) nreq++;
    end
    check_eq(tag, nreq, 32'd0);
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  logic [31:0] exp_fetch [$];
  logic [31:0] exp_sa [0:8];
  logic [31:0] exp_sd [0:8];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    imem_en = 1'b1;
    dly     = 4'd3;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;

    imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);        // addi x1,x0,5
    imem[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);        // addi x2,x0,7
    imem[2]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);         // add  x3,x1,x2
    imem[3]  = enc_s(12'd8, 5'd3, 5'd0);                            // sw   x3,8(x0)
    imem[4]  = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);        // lw   x4,8(x0)
    imem[5]  = enc_s(12'd12, 5'd4, 5'd0);                           // sw   x4,12(x0)
    imem[6]  = enc_b(13'd8, 5'd1, 5'd1, 3'b000);                    // beq  x1,x1,+8
    imem[7]  = enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011);        // addi x5,x0,1 (skipped)
    imem[8]  = enc_b(13'd8, 5'd1, 5'd1, 3'b001);                    // bne  x1,x1,+8
    imem[9]  = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);        // addi x0,x0,9
    imem[10] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd6);         // sub  x6,x1,x2
    imem[11] = enc_r(7'b0000000, 5'd1, 5'd6, 3'b010, 5'd7);         // slt  x7,x6,x1
    imem[12] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd8);         // and  x8,x1,x2
    imem[13] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd9);         // or   x9,x1,x2
    imem[14] = enc_j(21'd8, 5'd10);                                 // jal  x10,+8
    imem[15] = enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011);        // addi x5,x0,1 (skipped)
    imem[16] = enc_s(12'd16, 5'd0, 5'd0);                           // sw   x0,16(x0)
    imem[17] = enc_s(12'd20, 5'd6, 5'd0);                           // sw   x6,20(x0)
    imem[18] = enc_s(12'd24, 5'd7, 5'd0);                           // sw   x7,24(x0)
    imem[19] = enc_s(12'd28, 5'd8, 5'd0);                           // sw   x8,28(x0)
    imem[20] = enc_s(12'd32, 5'd9, 5'd0);                           // sw   x9,32(x0)
    imem[21] = enc_s(12'd36, 5'd10, 5'd0);                          // sw   x10,36(x0)
    imem[22] = enc_s(12'd40, 5'd5, 5'd0);                           // sw   x5,40(x0)
    imem[23] = enc_i(12'd2, 5'd0, 3'b010, 5'd11, 7'b0000011);       // lw   x11,2(x0) -> trap

    for (int w = 0; w < 24; w++) begin
      if ((w != 7) && (w != 15)) exp_fetch.push_back(32'(w) * 32'd4);
    end
    exp_sa[0] = 32'd8;  exp_sd[0] = 32'd12;
    exp_sa[1] = 32'd12; exp_sd[1] = 32'd12;
    exp_sa[2] = 32'd16; exp_sd[2] = 32'd0;
    exp_sa[3] = 32'd20; exp_sd[3] = 32'hFFFF_FFFE;
    exp_sa[4] = 32'd24; exp_sd[4] = 32'd1;
    exp_sa[5] = 32'd28; exp_sd[5] = 32'd5;
    exp_sa[6] = 32'd32; exp_sd[6] = 32'd7;
    exp_sa[7] = 32'd36; exp_sd[7] = 32'h0000_003C;
    exp_sa[8] = 32'd40; exp_sd[8] = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_imem_req",   {31'd0, imem_req}, 32'd0);
    check_eq("rst_imem_addr",  imem_addr,         32'd0);
    check_eq("rst_dmem_req",   {31'd0, dmem_req}, 32'd0);
    check_eq("rst_dmem_we",    {31'd0, dmem_we},  32'd0);
    check_eq("rst_dmem_addr",  dmem_addr,         32'd0);
    check_eq("rst_dmem_wdata", dmem_wdata,        32'd0);
    check_eq("rst_halt",       {31'd0, halt},     32'd0);
    check_eq("rst_pc",         pc_out,            32'd0);

    // Main program: exact latency of the first three instructions
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);                 // IDLE -> FETCH
    repeat (11) @(posedge clk);
    #1;
    check_eq("pc_after_11", pc_out, 32'd8);
    @(posedge clk);
    #1;
    check_eq("pc_after_12", pc_out, 32'd12);

    wait_halt(1000);
    check_eq("trap_pc", pc_out, 32'h0000_005C);
    check_eq("sw_hold_cycles", hold_cnt, 32'd4);
    check_eq("dmem_acks", n_dack, 32'd10);
    check_eq("store_count", st_addr.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check_eq("store_addr", (i < st_addr.size()) ? st_addr[i] : 32'hDEAD_BEEF, exp_sa[i]);
      check_eq("store_data", (i < st_data.size()) ? st_data[i] : 32'hDEAD_BEEF, exp_sd[i]);
    end
    check_eq("fetch_count", flog.size(), exp_fetch.size());
    for (int i = 0; i < exp_fetch.size(); i++) begin
      check_eq("fetch_addr", (i < flog.size()) ? flog[i] : 32'hDEAD_BEEF, exp_fetch[i]);
    end
    check_no_req("trap_misalign_noreq", 10);
`ifdef PERF_CNT_EN
    check_eq("instret_main", instret_cnt, 32'd21);
`endif

    // Illegal opcode program
    @(negedge clk);
    rst = 1'b1;
    imem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011);         // addi x1,x0,1
    imem[1] = 32'h0000_007F;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_clears_halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_halt(50);
    check_eq("illegal_pc", pc_out, 32'd4);
    check_no_req("trap_illegal_noreq", 8);
`ifdef PERF_CNT_EN
    check_eq("instret_illegal", instret_cnt, 32'd1);
`endif

    // Reset while a fetch is outstanding
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);                 // IDLE -> FETCH
    repeat (4) @(posedge clk);      // first instruction retires, fetch of 0x04 starts
    #1;
    imem_en = 1'b0;
    check_eq("midfetch_pc", pc_out, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    check_eq("fetch_req_held",  {31'd0, imem_req}, 32'd1);
    check_eq("fetch_addr_held", imem_addr,         32'd4);
    imem_en = 1'b1;                 // ack now pending together with reset
    rst     = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_req",  {31'd0, imem_req}, 32'd0);
    check_eq("rst_mid_pc",   pc_out,            32'd0);
    check_eq("rst_mid_halt", {31'd0, halt},     32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("restart_req",  {31'd0, imem_req}, 32'd1);
    check_eq("restart_addr", imem_addr,         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
